bsg_fifo_1r1w_mem_ctrl: RTL and testbench
=========================================

# bsg_fifo_1r1w_mem_ctrl

Ready/valid FIFO controller that owns the write and read ports of a 1r1w synthesized memory with `read_write_same_addr_p0` semantics. It tracks the enqueue and dequeue pointers and occupancy, issues memory writes, and presents the asynchronous memory read data as a valid-then-yumi output stream. It sits directly upstream of the `els_p`-entry storage array and makes it a FIFO for the pipeline stage that consumes it.

## Interface
Parameters:
- `width_p`, 109, data width; must equal the memory width.
- `els_p`, 2, number of entries; a power of two, at least 2.
- `ptr_width_lp`, `$clog2(els_p)`, derived; memory address width.

Ports:
- `clk_i`, in, 1, single clock; also drives the memory `w_clk_i`.
- `reset_i`, in, 1, synchronous, active-high reset; also drives the memory `w_reset_i`.
- `data_i`, in, `width_p`, enqueue data.
- `v_i`, in, 1, enqueue valid. The producer may assert it only while `ready_o` is high (ready-then-valid).
- `ready_o`, out, 1, the FIFO can accept an element this cycle.
- `data_o`, out, `width_p`, head element; equals `mem_r_data_i`.
- `v_o`, out, 1, head element valid.
- `yumi_i`, in, 1, consumer takes the head; legal only while `v_o` is high.
- `mem_w_v_o`, out, 1, memory write enable.
- `mem_w_addr_o`, out, `ptr_width_lp`, memory write address.
- `mem_w_data_o`, out, `width_p`, memory write data.
- `mem_r_v_o`, out, 1, memory read enable.
- `mem_r_addr_o`, out, `ptr_width_lp`, memory read address.
- `mem_r_data_i`, in, `width_p`, memory read data; combinational from `mem_r_addr_o`.
- `count_o`, out, `ptr_width_lp+1`, occupancy, 0..`els_p`.
- `error_o`, out, 1, sticky protocol-violation flag.

## Operation
State registers:
- `wptr_r` and `rptr_r`, each `ptr_width_lp+1` bits: an address plus a wrap bit.
- `error_r`.

Status decode:
- Empty when `wptr_r == rptr_r`.
- Full when the addresses are equal and the wrap bits differ.
- `count_o = wptr_r - rptr_r`, modulo 2^(`ptr_width_lp`+1).

Enqueue (`enq = v_i & ready_o`):
- `mem_w_v_o = enq`.
- `mem_w_addr_o` = address bits of `wptr_r`.
- `mem_w_data_o = data_i`.
- `wptr_r` increments by 1 and wraps naturally.

Dequeue (`deq = yumi_i & v_o`):
- `rptr_r` increments by 1.
- `mem_r_addr_o` = address bits of `rptr_r`.
- `mem_r_v_o = v_o`.

Outputs:
- `ready_o = ~full & ~reset_i`.
- `v_o = ~empty & ~reset_i`.

Same-address rule:
- A write and a read never target the same address in the same cycle while `mem_r_v_o` is high.
- Pointers are equal only when the FIFO is empty (read disabled) or full (write disabled).

Simultaneous enqueue and dequeue:
- Both are legal at any non-empty, non-full occupancy.
- Occupancy is unchanged.
- When full, `ready_o` is low, so no write happens even if `yumi_i` is asserted.
- When empty, `v_o` is low, so no dequeue happens.

Protocol violations:
- `v_i & ~ready_o`, or `yumi_i & ~v_o`, sets `error_r` on the next edge.
- The offending transfer is ignored and the pointers are unchanged.
- `error_o` clears only on reset.

Reset, synchronous:
- Sets `wptr_r = rptr_r = 0` and `error_r = 0`.
- Overrides any enqueue or dequeue in the same cycle; `mem_w_v_o` is 0 while `reset_i` is high.
- Memory contents are not cleared.

## Timing
- Reset values: `ready_o=0` and `v_o=0` during reset. The cycle after reset deasserts, `ready_o=1`, `v_o=0`, `count_o=0`, `error_o=0`, and `mem_w_v_o=0`, `mem_r_v_o=0` unless `v_i` is high that cycle.
- Enqueue latency:
  - Data enqueued at edge N (empty FIFO) appears on `data_o` with `v_o=1` in cycle N+1.
  - There is no same-cycle bypass.
- Dequeue to ready:
  - A dequeue at edge N from a full FIFO raises `ready_o` in cycle N+1.
  - `ready_o` depends only on registered state, never combinationally on `yumi_i`.
- `data_o` is combinational from `rptr_r` through the memory read path and is stable for the whole cycle `v_o` is high.
- Sustained throughput is one transfer per cycle in each direction when 0 < count < `els_p`.

## Test plan
- Reset with `v_i=1` and `yumi_i=1` held high: no memory write, no pointer movement. After release, `ready_o=1`, `v_o=0`, `count_o=0`, `error_o=0`.
- Enqueue 109'h1_2345 at cycle N -> in cycle N+1, `v_o=1`, `data_o=109'h1_2345`, `count_o=1`. Then `yumi_i=1` -> in N+2, `v_o=0`, `count_o=0`.
- With `els_p=2`, enqueue A then B with no yumi -> `ready_o=0`, `count_o=2`. Hold `v_i=1` with C -> `error_o=1`, C never written. Dequeues return A then B.
- Stream 10 elements with `v_i=yumi_i=1` every cycle after the first -> output order equals input order across pointer wrap, `count_o` constant at 1, no cycle with `mem_w_addr_o == mem_r_addr_o` while both enables are high.
- Assert `yumi_i` while empty -> `error_o=1`, pointers unchanged. Subsequent traffic is still correct.
- Reset asserted while full -> the next cycle after release reports empty, and a fresh enqueue reads back correctly.

Source files
------------

// File: rtl/bsg_fifo_1r1w_mem_ctrl_if.sv
// Handshake and memory-port bundle for the 1r1w FIFO memory controller.
// Slave modport is the controller's view; master is the producer/consumer/memory side.
// Parameters must match the controller instance they connect to.
interface bsg_fifo_1r1w_mem_ctrl_if #(
   parameter int width_p = 109,
   parameter int els_p   = 2
);
   localparam int ptr_width_lp = $clog2(els_p);

   // enqueue side
   logic [width_p-1:0]      data_i;
   logic                    v_i;
   logic                    ready_o;
   // dequeue side
   logic [width_p-1:0]      data_o;
   logic                    v_o;
   logic                    yumi_i;
   // memory write port
   logic                    mem_w_v_o;
   logic [ptr_width_lp-1:0] mem_w_addr_o;
   logic [width_p-1:0]      mem_w_data_o;
   // memory read port
   logic                    mem_r_v_o;
   logic [ptr_width_lp-1:0] mem_r_addr_o;
   logic [width_p-1:0]      mem_r_data_i;
   // status
   logic [ptr_width_lp:0]   count_o;
   logic                    error_o;

   modport slave (
      input  data_i, v_i, yumi_i, mem_r_data_i,
      output ready_o, data_o, v_o,
      output mem_w_v_o, mem_w_addr_o, mem_w_data_o,
      output mem_r_v_o, mem_r_addr_o,
      output count_o, error_o
   );

   modport master (
      output data_i, v_i, yumi_i, mem_r_data_i,
      input  ready_o, data_o, v_o,
      input  mem_w_v_o, mem_w_addr_o, mem_w_data_o,
      input  mem_r_v_o, mem_r_addr_o,
      input  count_o, error_o
   );
endinterface

// File: rtl/bsg_fifo_1r1w_mem_ctrl.sv
// FIFO controller that turns a 1r1w async-read memory into a ready/valid FIFO.
// Latency: an enqueue at edge N is visible on data_o/v_o in cycle N+1 (no bypass).
// Backpressure: ready_o drops only when full (registered state); illegal transfers are dropped and flagged sticky.
module bsg_fifo_1r1w_mem_ctrl #(
   parameter int width_p = 109,
   parameter int els_p   = 2
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   bsg_fifo_1r1w_mem_ctrl_if.slave  bus
);
   localparam int ptr_width_lp = $clog2(els_p);

   // address bits plus one wrap bit so full and empty are distinguishable
   typedef logic [ptr_width_lp:0] ptr_t;
   localparam ptr_t ptr_one_lp = ptr_t'(1);

   ptr_t wptr_r, rptr_r;
   logic error_r;

   logic empty, full;
   logic ready, valid;
   logic enq, deq;
   logic violation;

   assign empty = (wptr_r == rptr_r);
   assign full  = (wptr_r[ptr_width_lp-1:0] == rptr_r[ptr_width_lp-1:0])
                & (wptr_r[ptr_width_lp] != rptr_r[ptr_width_lp]);

   // Handshake status comes only from registered pointers, never from yumi_i.
   assign ready = ~full  & ~reset_i;
   assign valid = ~empty & ~reset_i;

   assign enq = bus.v_i    & ready;
   assign deq = bus.yumi_i & valid;

   // A producer pushing into a full FIFO or a consumer popping an empty one.
   assign violation = (bus.v_i & ~ready) | (bus.yumi_i & ~valid);

   assign bus.ready_o = ready;
   assign bus.v_o     = valid;
   assign bus.data_o  = bus.mem_r_data_i;

   // Write and read addresses only coincide when empty (read off) or full (write off).
   assign bus.mem_w_v_o    = enq;
   assign bus.mem_w_addr_o = wptr_r[ptr_width_lp-1:0];
   assign bus.mem_w_data_o = bus.data_i;
   assign bus.mem_r_v_o    = valid;
   assign bus.mem_r_addr_o = rptr_r[ptr_width_lp-1:0];

   assign bus.count_o = wptr_r - rptr_r;
   assign bus.error_o = error_r;

   // Pointer advance and sticky error capture; reset overrides any transfer.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wptr_r  <= '0;
         rptr_r  <= '0;
         error_r <= 1'b0;
      end else begin
         if (enq)       wptr_r  <= wptr_r + ptr_one_lp;
         if (deq)       rptr_r  <= rptr_r + ptr_one_lp;
         if (violation) error_r <= 1'b1;
      end
   end
endmodule

// File: tb/tb_bsg_fifo_1r1w_mem_ctrl.sv
// Self-checking bench for bsg_fifo_1r1w_mem_ctrl with a behavioural queue model.
// Includes a 1r1w async-read memory model as the storage array.
// Directed scenarios followed by randomized legal traffic.
module tb_bsg_fifo_1r1w_mem_ctrl;
   localparam int W   = 109;
   localparam int ELS = 2;
   localparam int PW  = $clog2(ELS);

   logic clk;
   logic reset_i;

   bsg_fifo_1r1w_mem_ctrl_if #(.width_p(W), .els_p(ELS)) bus ();

   bsg_fifo_1r1w_mem_ctrl #(.width_p(W), .els_p(ELS)) dut (
      .clk_i   (clk),
      .reset_i (reset_i),
      .bus     (bus)
   );

   // storage array: synchronous write, combinational read
   logic [W-1:0] mem [ELS];
   always @(posedge clk) begin
      if (bus.mem_w_v_o) mem[bus.mem_w_addr_o] <= bus.mem_w_data_o;
   end
   assign bus.mem_r_data_i = mem[bus.mem_r_addr_o];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int vectors    = 0;
   int miscompares = 0;

   // behavioural model: FIFO contents, sticky error, and transfer counts since reset
   logic [W-1:0] q [$];
   logic         m_err;
   int           n_enq, n_deq;

   function automatic logic [W-1:0] rand_data();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[W-1:0];
   endfunction

   // advance one clock edge and apply the FIFO rules to the model using the inputs seen at that edge
   task automatic tick();
      logic mready, mvalid;
      @(posedge clk);
      mready = (q.size() < ELS);
      mvalid = (q.size() > 0);
      if (reset_i) begin
         q.delete();
         m_err = 1'b0;
         n_enq = 0;
         n_deq = 0;
      end else begin
         if ((bus.v_i && !mready) || (bus.yumi_i && !mvalid)) m_err = 1'b1;
         if (bus.yumi_i && mvalid) begin
            q.delete(0);
            n_deq++;
         end
         if (bus.v_i && mready) begin
            q.push_back(bus.data_i);
            n_enq++;
         end
      end
      #1;
   endtask

   task automatic do_reset();
      reset_i     = 1'b1;
      bus.v_i     = 1'b0;
      bus.yumi_i  = 1'b0;
      bus.data_i  = '0;
      tick();
      tick();
      reset_i = 1'b0;
   endtask

   task automatic test_reset();
      reset_i    = 1'b1;
      bus.v_i    = 1'b1;
      bus.yumi_i = 1'b1;
      bus.data_i = rand_data();
      for (int c = 0; c < 3; c++) begin
         #1;
         vectors++;
         if ({bus.ready_o, bus.v_o, bus.mem_w_v_o} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_hold: ready/v/mem_w_v=%b want 000", {bus.ready_o, bus.v_o, bus.mem_w_v_o});
         end
         tick();
      end
      reset_i    = 1'b0;
      bus.v_i    = 1'b0;
      bus.yumi_i = 1'b0;
      #1;
      vectors++;
      if ({bus.ready_o, bus.v_o, bus.error_o, bus.mem_w_v_o, bus.mem_r_v_o} !== 5'b10000) begin
         miscompares++;
         $display("FAIL reset_release: ready/v/err/wv/rv=%b want 10000",
                  {bus.ready_o, bus.v_o, bus.error_o, bus.mem_w_v_o, bus.mem_r_v_o});
      end
      vectors++;
      if (bus.count_o !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_count: got %0d want 0", bus.count_o);
      end
   endtask

   task automatic test_single();
      logic [W-1:0] d;
      d = 109'h1_2345;
      do_reset();
      bus.v_i    = 1'b1;
      bus.data_i = d;
      #1;
      vectors++;
      if (bus.mem_w_v_o !== 1'b1 || bus.mem_w_addr_o !== PW'(0) || bus.mem_w_data_o !== d) begin
         miscompares++;
         $display("FAIL single_write: wv=%b addr=%0d data=%h want 1/0/%h",
                  bus.mem_w_v_o, bus.mem_w_addr_o, bus.mem_w_data_o, d);
      end
      vectors++;
      if (bus.v_o !== 1'b0) begin
         miscompares++;
         $display("FAIL single_no_bypass: v_o=%b want 0", bus.v_o);
      end
      tick();
      bus.v_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b1 || bus.data_o !== d || bus.count_o !== 2'd1) begin
         miscompares++;
         $display("FAIL single_read: v=%b data=%h count=%0d want 1/%h/1", bus.v_o, bus.data_o, bus.count_o, d);
      end
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b0 || bus.count_o !== 2'd0) begin
         miscompares++;
         $display("FAIL single_drain: v=%b count=%0d want 0/0", bus.v_o, bus.count_o);
      end
   endtask

   task automatic test_full_overflow();
      logic [W-1:0] a, b, c;
      a = rand_data();
      b = rand_data();
      c = rand_data();
      do_reset();
      bus.v_i = 1'b1;
      bus.data_i = a;
      tick();
      bus.data_i = b;
      tick();
      bus.v_i = 1'b0;
      #1;
      vectors++;
      if (bus.ready_o !== 1'b0 || bus.count_o !== 2'd2) begin
         miscompares++;
         $display("FAIL full_status: ready=%b count=%0d want 0/2", bus.ready_o, bus.count_o);
      end
      bus.v_i = 1'b1;
      bus.data_i = c;
      #1;
      vectors++;
      if (bus.mem_w_v_o !== 1'b0) begin
         miscompares++;
         $display("FAIL full_no_write: mem_w_v=%b want 0", bus.mem_w_v_o);
      end
      tick();
      bus.v_i = 1'b0;
      #1;
      vectors++;
      if (bus.error_o !== 1'b1 || bus.count_o !== 2'd2) begin
         miscompares++;
         $display("FAIL full_overflow_err: err=%b count=%0d want 1/2", bus.error_o, bus.count_o);
      end
      vectors++;
      if (bus.data_o !== a) begin
         miscompares++;
         $display("FAIL full_head_a: got %h want %h", bus.data_o, a);
      end
      bus.yumi_i = 1'b1;
      tick();
      #1;
      vectors++;
      if (bus.ready_o !== 1'b1 || bus.data_o !== b || bus.v_o !== 1'b1) begin
         miscompares++;
         $display("FAIL full_head_b: ready=%b v=%b data=%h want 1/1/%h", bus.ready_o, bus.v_o, bus.data_o, b);
      end
      tick();
      bus.yumi_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b0 || bus.count_o !== 2'd0 || bus.error_o !== 1'b1) begin
         miscompares++;
         $display("FAIL full_drained: v=%b count=%0d err=%b want 0/0/1", bus.v_o, bus.count_o, bus.error_o);
      end
   endtask

   task automatic test_stream();
      logic [W-1:0] sent [$];
      int got;
      got = 0;
      do_reset();
      for (int c = 0; c <= 10; c++) begin
         bus.v_i    = (c < 10);
         bus.yumi_i = (c > 0);
         bus.data_i = rand_data();
         if (c < 10) sent.push_back(bus.data_i);
         #1;
         if (c > 0) begin
            vectors++;
            if (bus.v_o !== 1'b1 || bus.data_o !== sent[got]) begin
               miscompares++;
               $display("FAIL stream_order[%0d]: v=%b data=%h want 1/%h", got, bus.v_o, bus.data_o, sent[got]);
            end
            got++;
         end
         if (c > 0 && c < 10) begin
            vectors++;
            if (bus.count_o !== 2'd1) begin
               miscompares++;
               $display("FAIL stream_count c=%0d: got %0d want 1", c, bus.count_o);
            end
         end
         vectors++;
         if (bus.mem_w_v_o && bus.mem_r_v_o && (bus.mem_w_addr_o == bus.mem_r_addr_o)) begin
            miscompares++;
            $display("FAIL stream_addr_clash c=%0d: addr=%0d both enables high", c, bus.mem_w_addr_o);
         end
         tick();
      end
      bus.v_i = 1'b0;
      bus.yumi_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b0 || bus.count_o !== 2'd0 || bus.error_o !== 1'b0) begin
         miscompares++;
         $display("FAIL stream_end: v=%b count=%0d err=%b want 0/0/0", bus.v_o, bus.count_o, bus.error_o);
      end
   endtask

   task automatic test_yumi_empty();
      logic [W-1:0] e;
      e = rand_data();
      do_reset();
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
      #1;
      vectors++;
      if (bus.error_o !== 1'b1 || bus.count_o !== 2'd0 || bus.v_o !== 1'b0) begin
         miscompares++;
         $display("FAIL underflow: err=%b count=%0d v=%b want 1/0/0", bus.error_o, bus.count_o, bus.v_o);
      end
      bus.v_i = 1'b1;
      bus.data_i = e;
      tick();
      bus.v_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b1 || bus.data_o !== e || bus.count_o !== 2'd1 || bus.mem_r_addr_o !== PW'(0)) begin
         miscompares++;
         $display("FAIL underflow_recover: v=%b data=%h count=%0d raddr=%0d want 1/%h/1/0",
                  bus.v_o, bus.data_o, bus.count_o, bus.mem_r_addr_o, e);
      end
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
   endtask

   task automatic test_reset_full();
      logic [W-1:0] d;
      do_reset();
      bus.v_i = 1'b1;
      for (int c = 0; c < ELS; c++) begin
         bus.data_i = rand_data();
         tick();
      end
      bus.v_i = 1'b0;
      reset_i = 1'b1;
      tick();
      reset_i = 1'b0;
      #1;
      vectors++;
      if ({bus.ready_o, bus.v_o, bus.error_o} !== 3'b100 || bus.count_o !== 2'd0) begin
         miscompares++;
         $display("FAIL reset_full: ready/v/err=%b count=%0d want 100/0", {bus.ready_o, bus.v_o, bus.error_o}, bus.count_o);
      end
      d = rand_data();
      bus.v_i = 1'b1;
      bus.data_i = d;
      tick();
      bus.v_i = 1'b0;
      #1;
      vectors++;
      if (bus.v_o !== 1'b1 || bus.data_o !== d) begin
         miscompares++;
         $display("FAIL reset_full_fresh: v=%b data=%h want 1/%h", bus.v_o, bus.data_o, d);
      end
      bus.yumi_i = 1'b1;
      tick();
      bus.yumi_i = 1'b0;
   endtask

   task automatic test_random();
      logic mready, mvalid;
      do_reset();
      for (int c = 0; c < 400; c++) begin
         mready = (q.size() < ELS);
         mvalid = (q.size() > 0);
         bus.v_i    = mready && ($urandom_range(0, 3) != 0);
         bus.yumi_i = mvalid && ($urandom_range(0, 3) != 0);
         bus.data_i = rand_data();
         #1;
         vectors++;
         if (bus.ready_o !== mready || bus.v_o !== mvalid || bus.error_o !== m_err
             || bus.count_o !== (PW + 1)'(q.size())) begin
            miscompares++;
            $display("FAIL random_status c=%0d: ready=%b v=%b err=%b count=%0d want %b/%b/%b/%0d",
                     c, bus.ready_o, bus.v_o, bus.error_o, bus.count_o, mready, mvalid, m_err, q.size());
         end
         if (mvalid) begin
            vectors++;
            if (bus.data_o !== q[0] || bus.mem_r_addr_o !== PW'(n_deq % ELS)) begin
               miscompares++;
               $display("FAIL random_head c=%0d: data=%h raddr=%0d want %h/%0d",
                        c, bus.data_o, bus.mem_r_addr_o, q[0], n_deq % ELS);
            end
         end
         vectors++;
         if (bus.mem_w_v_o !== bus.v_i
             || (bus.v_i && bus.mem_w_addr_o !== PW'(n_enq % ELS))) begin
            miscompares++;
            $display("FAIL random_write c=%0d: wv=%b waddr=%0d want %b/%0d",
                     c, bus.mem_w_v_o, bus.mem_w_addr_o, bus.v_i, n_enq % ELS);
         end
         vectors++;
         if (bus.mem_w_v_o && bus.mem_r_v_o && (bus.mem_w_addr_o == bus.mem_r_addr_o)) begin
            miscompares++;
            $display("FAIL random_addr_clash c=%0d: addr=%0d", c, bus.mem_w_addr_o);
         end
         tick();
      end
      bus.v_i = 1'b0;
      bus.yumi_i = 1'b0;
   endtask

   initial begin
      reset_i    = 1'b1;
      bus.v_i    = 1'b0;
      bus.yumi_i = 1'b0;
      bus.data_i = '0;
      m_err      = 1'b0;
      n_enq      = 0;
      n_deq      = 0;
      tick();
      test_reset();
      test_single();
      test_full_overflow();
      test_stream();
      test_yumi_empty();
      test_reset_full();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
